store_buffer: RTL

In-order buffer for store operations on the write side of data memory; counterpart to the load buffer's read path. Stores are allocated by the ACU with address and data resolved, marked committed as the ROB retires them, and drained to memory one per handshake. It drives `pending_stores` to the load buffer, which holds loads back until every buffered store has reached memory. A branch misprediction discards all uncommitted entries.

---
 rtl/store_buffer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : In-order store buffer between the ACU and data memory.
//                Stores are allocated with address/data resolved, marked
//                committed as the ROB retires them, and drained to memory
//                one per handshake. Uncommitted entries are discarded on a
//                branch misprediction.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH       = 4,
  parameter int XLEN        = 32,
  parameter int ROB_TAG_LEN = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alloc_enable,
  input  logic [XLEN-1:0]            alloc_address,
  input  logic [XLEN-1:0]            alloc_data,
  input  logic [1:0]                 alloc_size,
  input  logic [ROB_TAG_LEN-1:0]     alloc_rob_tag,
  input  logic                       commit_store,
  input  logic [ROB_TAG_LEN-1:0]     commit_rob_tag,
  input  logic                       branch_misprediction,
  input  logic                       Dmem_ready,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       pending_stores,
  output logic                       write_mem,
  output logic [XLEN-1:0]            write_address,
  output logic [XLEN-1:0]            write_data,
  output logic [1:0]                 write_size
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
  localparam logic [PTR_W-1:0] c_depth   = PTR_W'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W-1:0]       r_head;
  logic [PTR_W-1:0]       r_cmt;
  logic [PTR_W-1:0]       r_tail;

  logic [XLEN-1:0]        r_addr [DEPTH];
  logic [XLEN-1:0]        r_data [DEPTH];
  logic [1:0]             r_size [DEPTH];
  logic [ROB_TAG_LEN-1:0] r_tag  [DEPTH];

  logic [IDX_W-1:0]       w_head_idx;
  logic [IDX_W-1:0]       w_cmt_idx;
  logic [IDX_W-1:0]       w_tail_idx;
  logic [PTR_W-1:0]       w_count;
  logic                   w_full;
  logic                   w_alloc;
  logic                   w_commit;
  logic                   w_drain;
  logic [PTR_W-1:0]       w_cmt_next;

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_cmt_idx  = r_cmt[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];

  assign w_count = r_tail - r_head;
  assign w_full  = (w_count == c_depth);

  // A misprediction wins over an allocation in the same cycle.
  assign w_alloc  = alloc_enable && !w_full && !branch_misprediction;
  assign w_commit = commit_store && (r_cmt != r_tail) &&
                    (commit_rob_tag == r_tag[w_cmt_idx]);
  assign w_drain  = write_mem && Dmem_ready;

  // The squash target includes a commit that lands in the same cycle.
  assign w_cmt_next = w_commit ? (r_cmt + c_ptr_one) : r_cmt;

  // Outputs depend only on registered state.
  assign full           = w_full;
  assign count          = w_count;
  assign pending_stores = (w_count != '0);
  assign write_mem      = (r_head != r_cmt);
  assign write_address  = r_addr[w_head_idx];
  assign write_data     = r_data[w_head_idx];
  assign write_size     = r_size[w_head_idx];

  // Pointer updates: drain moves head, commit moves cmt, alloc/squash move tail.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head <= '0;
      r_cmt  <= '0;
      r_tail <= '0;
    end else begin
      if (w_drain) begin
        r_head <= r_head + c_ptr_one;
      end
      r_cmt <= w_cmt_next;
      if (branch_misprediction) begin
        r_tail <= w_cmt_next;
      end else if (w_alloc) begin
        r_tail <= r_tail + c_ptr_one;
      end
    end
  end

  // Entry storage: written at the tail slot on allocation, cleared on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_size[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else if (w_alloc) begin
      r_addr[w_tail_idx] <= alloc_address;
      r_data[w_tail_idx] <= alloc_data;
      r_size[w_tail_idx] <= alloc_size;
      r_tag[w_tail_idx]  <= alloc_rob_tag;
    end
  end

endmodule
`default_nettype wire
